// File: rtl/stack_mem_responder.sv
// Byte-wide memory responder for the stack-machine CPU: combinational read path,
// marker-then-value store decode, and a host preload port that holds the CPU in reset.
module stack_mem_responder #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  MARKER    = 8'hFF,
    parameter logic [7:0]  LOAD_FILL = 8'h0F
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_reset,
    input  logic              host_load,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              store_pulse,
    output logic [ADDR_W-1:0] last_st_addr,
    output logic [7:0]        last_st_data,
    output logic [7:0]        store_count
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, ARMED, LOAD} state_t;

    state_t              state_q, state_d;
    logic                prev_mark_q, prev_mark_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                store_pulse_q, store_pulse_d;
    logic [ADDR_W-1:0]   last_st_addr_q, last_st_addr_d;
    logic [7:0]          last_st_data_q, last_st_data_d;
    logic [7:0]          store_count_q, store_count_d;
    logic [7:0]          mem_q [DEPTH];

    logic                is_mark, arm, commit;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          wr_data;

    assign is_mark = (cpu_wdata == MARKER);
    assign arm     = is_mark && !prev_mark_q;

    always_comb begin
        state_d        = state_q;
        prev_mark_d    = is_mark;
        commit         = 1'b0;
        last_st_addr_d = last_st_addr_q;
        last_st_data_d = last_st_data_q;
        store_count_d  = store_count_q;
        wr_en          = 1'b0;
        wr_addr        = cpu_addr;
        wr_data        = cpu_wdata;
        case (state_q)
            IDLE: begin
                if (host_load)  state_d = LOAD;
                else if (arm)   state_d = ARMED;
            end
            ARMED: begin
                // A host takeover during the value cycle abandons the store.
                if (host_load) begin
                    state_d = LOAD;
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                wr_en   = host_we;
                wr_addr = host_addr;
                wr_data = host_wdata;
                if (!host_load) begin
                    state_d     = IDLE;
                    prev_mark_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            wr_en          = 1'b1;
            last_st_addr_d = cpu_addr;
            last_st_data_d = cpu_wdata;
            if (store_count_q != 8'hFF) store_count_d = store_count_q + 8'd1;
        end
        store_pulse_d = commit;
        cpu_reset_d   = (state_d == LOAD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            prev_mark_q    <= 1'b1;
            cpu_reset_q    <= 1'b1;
            store_pulse_q  <= 1'b0;
            last_st_addr_q <= '0;
            last_st_data_q <= '0;
            store_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            prev_mark_q    <= prev_mark_d;
            cpu_reset_q    <= cpu_reset_d;
            store_pulse_q  <= store_pulse_d;
            last_st_addr_q <= last_st_addr_d;
            last_st_data_q <= last_st_data_d;
            store_count_q  <= store_count_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // The CPU samples data on the same edge it presents the address, so reads bypass any register.
    assign cpu_rdata    = (state_q == LOAD) ? LOAD_FILL : mem_q[cpu_addr];
    assign host_rdata   = mem_q[host_addr];
    assign cpu_reset    = cpu_reset_q;
    assign store_pulse  = store_pulse_q;
    assign last_st_addr = last_st_addr_q;
    assign last_st_data = last_st_data_q;
    assign store_count  = store_count_q;
endmodule

// File: tb/tb_stack_mem_responder.sv
// Directed bench for stack_mem_responder: host preload, store decode, marker corner cases,
// abort by host takeover, counter saturation and reset during a store.
module tb_stack_mem_responder;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_reset, host_load, host_we;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       store_pulse;
    logic [7:0] last_st_addr, last_st_data, store_count;

    int n_cmp = 0;
    int n_bad = 0;

    stack_mem_responder #(.ADDR_W(8), .MARKER(8'hFF), .LOAD_FILL(8'h0F)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_reset(cpu_reset),
        .host_load(host_load), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .store_pulse(store_pulse), .last_st_addr(last_st_addr),
        .last_st_data(last_st_data), .store_count(store_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        host_load = 1'b0; host_we = 1'b0; host_addr = 8'h05; host_wdata = 8'h00;
        #12;
        n_cmp++; if (cpu_reset !== 1'b1) begin $display("FAIL rst_cpu_reset got %h want 1", cpu_reset); n_bad++; end
        n_cmp++; if (store_pulse !== 1'b0) begin $display("FAIL rst_pulse got %h want 0", store_pulse); n_bad++; end
        n_cmp++; if (store_count !== 8'h00) begin $display("FAIL rst_count got %h want 00", store_count); n_bad++; end
        n_cmp++; if (last_st_addr !== 8'h00 || last_st_data !== 8'h00) begin $display("FAIL rst_last got %h/%h want 00/00", last_st_addr, last_st_data); n_bad++; end
        n_cmp++; if (host_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin $display("FAIL rst_mem got %h/%h want 00/00", host_rdata, cpu_rdata); n_bad++; end
    endtask

    task automatic test_load();
        logic [7:0] prog [4];
        prog[0] = 8'h08; prog[1] = 8'h2A; prog[2] = 8'h0A; prog[3] = 8'h40;
        reset_n = 1'b1; host_load = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            host_we = 1'b1; host_addr = i[7:0]; host_wdata = prog[i];
            tick();
            n_cmp++; if (cpu_reset !== 1'b1) begin $display("FAIL load_cpu_reset[%0d] got %h want 1", i, cpu_reset); n_bad++; end
            n_cmp++; if (cpu_rdata !== 8'h0F) begin $display("FAIL load_fill[%0d] got %h want 0f", i, cpu_rdata); n_bad++; end
        end
        host_we = 1'b0; host_addr = 8'h02; cpu_addr = 8'h01;
        #1;
        n_cmp++; if (host_rdata !== 8'h0A) begin $display("FAIL load_host_rdata got %h want 0a", host_rdata); n_bad++; end
        host_load = 1'b0;
        #1;
        n_cmp++; if (cpu_reset !== 1'b1) begin $display("FAIL load_release_same got %h want 1", cpu_reset); n_bad++; end
        tick();
        n_cmp++; if (cpu_reset !== 1'b0) begin $display("FAIL load_release_next got %h want 0", cpu_reset); n_bad++; end
        n_cmp++; if (cpu_rdata !== 8'h2A) begin $display("FAIL load_cpu_read got %h want 2a", cpu_rdata); n_bad++; end
    endtask

    task automatic test_store();
        cpu_wdata = 8'h00; tick();
        cpu_wdata = 8'hFF; cpu_addr = 8'h03; tick();
        cpu_wdata = 8'h2A; cpu_addr = 8'h40; host_addr = 8'h40;
        #1;
        n_cmp++; if (host_rdata !== 8'h00) begin $display("FAIL store_before got %h want 00", host_rdata); n_bad++; end
        tick();
        n_cmp++; if (store_pulse !== 1'b1) begin $display("FAIL store_pulse got %h want 1", store_pulse); n_bad++; end
        n_cmp++; if (cpu_rdata !== 8'h2A) begin $display("FAIL store_visible got %h want 2a", cpu_rdata); n_bad++; end
        n_cmp++; if (last_st_addr !== 8'h40 || last_st_data !== 8'h2A) begin $display("FAIL store_last got %h/%h want 40/2a", last_st_addr, last_st_data); n_bad++; end
        n_cmp++; if (store_count !== 8'd1) begin $display("FAIL store_count got %0d want 1", store_count); n_bad++; end
        cpu_wdata = 8'h00; tick();
        n_cmp++; if (store_pulse !== 1'b0) begin $display("FAIL store_pulse_end got %h want 0", store_pulse); n_bad++; end
    endtask

    task automatic test_store_ff();
        int pulses = 0;
        cpu_wdata = 8'hFF; cpu_addr = 8'h10; tick(); pulses += int'(store_pulse);
        cpu_wdata = 8'hFF; cpu_addr = 8'h20; tick(); pulses += int'(store_pulse);
        cpu_wdata = 8'h00; tick(); pulses += int'(store_pulse);
        tick(); pulses += int'(store_pulse);
        host_addr = 8'h20; #1;
        n_cmp++; if (host_rdata !== 8'hFF) begin $display("FAIL ff_mem got %h want ff", host_rdata); n_bad++; end
        n_cmp++; if (pulses != 1) begin $display("FAIL ff_pulses got %0d want 1", pulses); n_bad++; end
        n_cmp++; if (store_count !== 8'd2) begin $display("FAIL ff_count got %0d want 2", store_count); n_bad++; end
    endtask

    task automatic test_hold_marker();
        int pulses = 0;
        cpu_wdata = 8'hFF; cpu_addr = 8'h30;
        for (int i = 0; i < 10; i++) begin
            tick(); pulses += int'(store_pulse);
        end
        cpu_wdata = 8'h00; tick(); pulses += int'(store_pulse);
        host_addr = 8'h30; #1;
        n_cmp++; if (pulses != 1) begin $display("FAIL hold_pulses got %0d want 1", pulses); n_bad++; end
        n_cmp++; if (store_count !== 8'd3) begin $display("FAIL hold_count got %0d want 3", store_count); n_bad++; end
        n_cmp++; if (host_rdata !== 8'hFF) begin $display("FAIL hold_mem got %h want ff", host_rdata); n_bad++; end
    endtask

    task automatic test_abort();
        cpu_wdata = 8'hFF; cpu_addr = 8'h50; tick();
        host_load = 1'b1; cpu_wdata = 8'h77; host_addr = 8'h50; tick();
        n_cmp++; if (host_rdata !== 8'h00) begin $display("FAIL abort_mem got %h want 00", host_rdata); n_bad++; end
        n_cmp++; if (store_count !== 8'd3 || store_pulse !== 1'b0) begin $display("FAIL abort_count got %0d/%h want 3/0", store_count, store_pulse); n_bad++; end
        n_cmp++; if (cpu_reset !== 1'b1 || cpu_rdata !== 8'h0F) begin $display("FAIL abort_load got %h/%h want 1/0f", cpu_reset, cpu_rdata); n_bad++; end
        host_load = 1'b0; cpu_wdata = 8'h00; tick();
        n_cmp++; if (cpu_reset !== 1'b0) begin $display("FAIL abort_exit got %h want 0", cpu_reset); n_bad++; end
    endtask

    task automatic test_saturate();
        int exp_cnt = 3;
        logic [7:0] v = 8'h00;
        logic [7:0] a = 8'h00;
        for (int i = 0; i < 300; i++) begin
            v = 8'(i * 7 + 3);
            a = 8'(i + 100);
            cpu_wdata = 8'h00; tick();
            cpu_wdata = 8'hFF; cpu_addr = 8'h01; tick();
            cpu_wdata = v; cpu_addr = a; tick();
            if (exp_cnt < 255) exp_cnt++;
            if (i >= 248 && i <= 254) begin
                n_cmp++; if (store_count !== 8'(exp_cnt)) begin $display("FAIL sat_count[%0d] got %0d want %0d", i, store_count, exp_cnt); n_bad++; end
            end
        end
        cpu_wdata = 8'h00; host_addr = a; tick();
        n_cmp++; if (store_count !== 8'd255) begin $display("FAIL sat_final got %0d want 255", store_count); n_bad++; end
        n_cmp++; if (last_st_data !== v || last_st_addr !== a) begin $display("FAIL sat_last got %h/%h want %h/%h", last_st_data, last_st_addr, v, a); n_bad++; end
        n_cmp++; if (host_rdata !== v) begin $display("FAIL sat_mem got %h want %h", host_rdata, v); n_bad++; end
    endtask

    task automatic test_reset_mid_store();
        cpu_wdata = 8'hFF; cpu_addr = 8'h60; tick();
        cpu_wdata = 8'h99; cpu_addr = 8'h40; host_addr = 8'h60;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (store_count !== 8'd0 || last_st_data !== 8'h00 || last_st_addr !== 8'h00) begin $display("FAIL mid_regs got %h/%h/%h want 00/00/00", store_count, last_st_data, last_st_addr); n_bad++; end
        n_cmp++; if (cpu_reset !== 1'b1 || store_pulse !== 1'b0) begin $display("FAIL mid_ctrl got %h/%h want 1/0", cpu_reset, store_pulse); n_bad++; end
        tick();
        n_cmp++; if (cpu_rdata !== 8'h00 || host_rdata !== 8'h00) begin $display("FAIL mid_mem got %h/%h want 00/00", cpu_rdata, host_rdata); n_bad++; end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_store_ff();
        test_hold_marker();
        test_abort();
        test_saturate();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stack_mem_responder.md
Name: stack_mem_responder

Overview:
- Memory-side responder for the stack-machine CPU's 8-bit bus. It owns a DEPTH x 8 memory and supplies instruction and data bytes combinationally on the CPU read path.
- It decodes the store protocol (marker byte 0xFF on the CPU write bus, then the value byte on the next cycle) and commits the value to memory.
- A host load port preloads programs while the responder holds the CPU in reset.
- Sits between the CPU core and the chip pins/host.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W.
- MARKER, 8'hFF, store-marker byte on cpu_wdata.
- LOAD_FILL, 8'h0F, byte returned on cpu_rdata during LOAD (NUL opcode).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  CPU address (CPU mem_addr).
- cpu_wdata  in  8  CPU write bus (CPU data_out).
- cpu_rdata  out  8  read data to the CPU (CPU data_in).
- cpu_reset  out  1  synchronous active-high reset to the CPU.
- host_load  in  1  host owns memory while high.
- host_we  in  1  host write strobe; honoured only in LOAD.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  8  host write data.
- host_rdata  out  8  mem[host_addr], combinational, in any state.
- store_pulse  out  1  one-cycle high on each committed CPU store.
- last_st_addr  out  ADDR_W  address of the most recent CPU store.
- last_st_data  out  8  data of the most recent CPU store.
- store_count  out  8  committed CPU stores, saturating at 255.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE, prev_mark=1, cpu_reset=1.
  - store_pulse=0, last_st_addr=0, last_st_data=0, store_count=0.
  - All memory bytes cleared to 0x00.
- Read path:
  - cpu_rdata = mem[cpu_addr] combinationally (zero-latency; the CPU latches data_in on the same edge it drives the address).
  - In LOAD, cpu_rdata = LOAD_FILL.
- prev_mark register: every cycle, prev_mark <= (cpu_wdata==MARKER).
- arm = (cpu_wdata==MARKER) && !prev_mark, i.e. rising-edge detection of the marker.
- FSM states IDLE, ARMED, LOAD:
  - IDLE: if host_load, go to LOAD. Else if arm, go to ARMED. Else stay.
  - ARMED (the value cycle):
    - If host_load: go to LOAD with no write (store aborted).
    - Else, at the clock edge: mem[cpu_addr] <= cpu_wdata; last_st_addr/last_st_data updated; store_count++ (saturating); store_pulse=1 in the following cycle; go to IDLE.
    - The value is committed even when it equals MARKER. Because prev_mark is then 1, it does not re-arm.
  - LOAD:
    - If host_we, mem[host_addr] <= host_wdata at the edge.
    - When host_load drops, go to IDLE. prev_mark is forced to 1 on exit.
- cpu_reset: registered, cpu_reset <= (next_state==LOAD). It is 1 out of reset, so the CPU sees at least one reset edge.
- Write visibility: a committed byte is visible on cpu_rdata/host_rdata in the cycle after the commit edge.
- Back-to-back CPU stores re-arm correctly, because the CPU FETCH cycle drives cpu_wdata=0 between stores.
- Host write and CPU commit cannot collide: host_we is ignored outside LOAD.
- Address wrap: addresses are ADDR_W bits and have no out-of-range case.
- Known limitation: a RET whose top-of-stack is 0xFF arms once and commits one 0xFF to cpu_addr (0 during EX_RET). Programs must not return 0xFF.
- Reset mid-store (reset_n low while in ARMED): no write; all registers return to reset values.

Test Plan:
- Reset, then host_load=1 and write 0x08,0x2A,0x0A,0x40 to addresses 0..3, then release: cpu_reset is 1 throughout LOAD and drops 1 cycle after release; cpu_rdata=0x0F during LOAD; host_rdata[2]=0x0A.
- In IDLE, drive cpu_wdata 0x00 -> 0xFF (cpu_addr=3) -> 0x2A (cpu_addr=0x40) -> 0x00: mem[0x40]=0x2A next cycle; store_pulse high for 1 cycle; last_st_addr=0x40; store_count=1.
- Store of the value 0xFF (cpu_wdata 0xFF,0xFF,0x00): exactly one commit of 0xFF; store_count increments by 1 only.
- cpu_wdata held at 0xFF for 10 cycles: exactly one commit, with no re-arming while the marker is held.
- host_load asserted during the ARMED cycle: no memory write, store_count unchanged, state LOAD, cpu_reset=1.
- 300 valid store sequences: store_count saturates at 255; final last_st_data matches the last value stored.
